traffic_sequencer: RTL and testbench

TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

---
 rtl/traffic_pkg.sv | 43 ++++
 rtl/phase_timer.sv | 37 +++
 rtl/traffic_sequencer.sv | 96 +++++++++
 tb/tb_traffic_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic sequencer: phase enum, lamp
// encodings and per-phase durations in ticks.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    PED_WALK    = 3'd6
  } state_e;

  // Lamp vectors are {red, yellow, green}
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] DUR_MAIN_GREEN  = 6'd12;
  localparam logic [CNT_W-1:0] DUR_MAIN_YELLOW = 6'd3;
  localparam logic [CNT_W-1:0] DUR_ALL_RED_A   = 6'd1;
  localparam logic [CNT_W-1:0] DUR_SIDE_GREEN  = 6'd10;
  localparam logic [CNT_W-1:0] DUR_SIDE_YELLOW = 6'd3;
  localparam logic [CNT_W-1:0] DUR_ALL_RED_B   = 6'd1;
  localparam logic [CNT_W-1:0] DUR_PED_WALK    = 6'd10;

  function automatic logic [CNT_W-1:0] phase_duration(input state_e s);
    case (s)
      MAIN_GREEN:  return DUR_MAIN_GREEN;
      MAIN_YELLOW: return DUR_MAIN_YELLOW;
      ALL_RED_A:   return DUR_ALL_RED_A;
      SIDE_GREEN:  return DUR_SIDE_GREEN;
      SIDE_YELLOW: return DUR_SIDE_YELLOW;
      ALL_RED_B:   return DUR_ALL_RED_B;
      PED_WALK:    return DUR_PED_WALK;
      default:     return DUR_MAIN_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick counter for one phase: flags the terminal tick against the loaded
// duration and restarts from zero on a synchronous clear.
module phase_timer
  import traffic_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] duration_i,
  output logic [CNT_W-1:0] count_o,
  output logic             term_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign term_o  = tick_i && (count_q == (duration_i - 6'd1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + 6'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/traffic_sequencer.sv
// Main/side road traffic light sequencer with pedestrian walk phase; phase
// timing is counted in ticks and lamps are decoded from the registered state.
module traffic_sequencer
  import traffic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             ped,
  input  logic             side_car,
  output logic [2:0]       mainTraffic,
  output logic [2:0]       sideTraffic,
  output logic             walk,
  output logic [CNT_W-1:0] counter,
  output logic             phase_done,
  output logic             ped_pending
);

  state_e           state_q, state_d;
  logic             ped_pending_q, ped_pending_d;
  logic             phase_done_q;
  logic             advance;
  logic             enter_walk;
  logic [CNT_W-1:0] duration;

  assign duration = phase_duration(state_q);

  // The terminal tick both advances the phase and clears the timer.
  phase_timer u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .tick_i     (tick),
    .clr_i      (advance),
    .duration_i (duration),
    .count_o    (counter),
    .term_o     (advance)
  );

  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        MAIN_GREEN:  state_d = (side_car || ped_pending_q) ? MAIN_YELLOW : MAIN_GREEN;
        MAIN_YELLOW: state_d = ALL_RED_A;
        ALL_RED_A:   state_d = SIDE_GREEN;
        SIDE_GREEN:  state_d = SIDE_YELLOW;
        SIDE_YELLOW: state_d = ALL_RED_B;
        ALL_RED_B:   state_d = ped_pending_q ? PED_WALK : MAIN_GREEN;
        PED_WALK:    state_d = MAIN_GREEN;
        default:     state_d = MAIN_GREEN;
      endcase
    end
  end

  // Requests arriving on the walk-entry edge or during the walk are dropped.
  assign enter_walk = (state_d == PED_WALK) && (state_q != PED_WALK);

  always_comb begin
    ped_pending_d = ped_pending_q;
    if (enter_walk) begin
      ped_pending_d = 1'b0;
    end else if (ped && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= MAIN_GREEN;
      ped_pending_q <= 1'b0;
      phase_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      phase_done_q  <= advance;
    end
  end

  always_comb begin
    mainTraffic = LAMP_RED;
    sideTraffic = LAMP_RED;
    walk        = 1'b0;
    case (state_q)
      MAIN_GREEN:  mainTraffic = LAMP_GREEN;
      MAIN_YELLOW: mainTraffic = LAMP_YELLOW;
      SIDE_GREEN:  sideTraffic = LAMP_GREEN;
      SIDE_YELLOW: sideTraffic = LAMP_YELLOW;
      PED_WALK:    walk        = 1'b1;
      default:     ;
    endcase
  end

  assign phase_done  = phase_done_q;
  assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Scoreboard bench for traffic_sequencer: a phase-table reference model
// predicts outputs per cycle and a monitor compares them after each edge.
module tb_traffic_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ped = 1'b0;
  logic       side_car = 1'b0;
  logic [2:0] mainTraffic, sideTraffic;
  logic       walk;
  logic [5:0] counter;
  logic       phase_done, ped_pending;

  traffic_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .ped         (ped),
    .side_car    (side_car),
    .mainTraffic (mainTraffic),
    .sideTraffic (sideTraffic),
    .walk        (walk),
    .counter     (counter),
    .phase_done  (phase_done),
    .ped_pending (ped_pending)
  );

  always #5 clk = ~clk;

  localparam int MG = 0, MY = 1, ARA = 2, SG = 3, SY = 4, ARB = 5, PW = 6;
  int         dur   [7] = '{12, 3, 1, 10, 3, 1, 10};
  logic [2:0] mlamp [7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] slamp [7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

  typedef struct {
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
    logic [5:0] c;
    logic       pd;
    logic       pp;
  } exp_t;

  exp_t sb[$];

  int m_phase = MG;
  int m_cnt   = 0;
  bit m_pend  = 1'b0;
  bit m_pd    = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int next_phase(input int p, input bit side, input bit pend);
    if (p == MG)  return (side || pend) ? MY : MG;
    if (p == ARB) return pend ? PW : MG;
    if (p == PW)  return MG;
    return p + 1;
  endfunction

  task automatic model_update(input bit r, input bit t, input bit p, input bit s);
    int np;
    if (r) begin
      m_phase = MG; m_cnt = 0; m_pend = 1'b0; m_pd = 1'b0;
    end else begin
      np   = m_phase;
      m_pd = 1'b0;
      if (t) begin
        if (m_cnt == dur[m_phase] - 1) begin
          m_pd  = 1'b1;
          m_cnt = 0;
          np    = next_phase(m_phase, s, m_pend);
        end else begin
          m_cnt++;
        end
      end
      if (np == PW && m_phase != PW) m_pend = 1'b0;
      else if (p && m_phase != PW)   m_pend = 1'b1;
      m_phase = np;
    end
  endtask

  task automatic step(input bit r, input bit t, input bit p, input bit s);
    exp_t e;
    @(negedge clk);
    reset = r; tick = t; ped = p; side_car = s;
    model_update(r, t, p, s);
    e.m  = mlamp[m_phase];
    e.s  = slamp[m_phase];
    e.w  = (m_phase == PW);
    e.c  = m_cnt[5:0];
    e.pd = m_pd;
    e.pp = m_pend;
    sb.push_back(e);
  endtask

  task automatic run_until(input int ph, input int cn, input bit t, input bit p, input bit s);
    int n = 0;
    while (!(m_phase == ph && m_cnt == cn)) begin
      step(1'b0, t, p, s);
      n++;
      if (n > 2000) begin
        n_miss++;
        $display("FAIL run_until timeout: got phase %0d expected phase %0d", m_phase, ph);
        break;
      end
    end
  endtask

  // Monitor: compare each predicted vector just after the edge it describes
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("mainTraffic", mainTraffic, e.m);
        check("sideTraffic", sideTraffic, e.s);
        check("walk", walk, e.w);
        check("counter", counter, e.c);
        check("phase_done", phase_done, e.pd);
        check("ped_pending", ped_pending, e.pp);
        check("main_onehot", $countones(mainTraffic), 1);
        check("side_onehot", $countones(sideTraffic), 1);
        check("no_dual_green", int'(mainTraffic[0] && sideTraffic[0]), 0);
      end
    end
  end

  initial begin
    bit s_rand = 1'b0;
    // Reset state
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    // Idle main road: 30 ticks, stays in MAIN_GREEN with periodic phase_done
    repeat (30) step(1'b0, 1'b1, 1'b0, 1'b0);
    // Side car: full side cycle back to MAIN_GREEN
    run_until(MG, 0, 1'b1, 1'b0, 1'b0);
    repeat (2 * 12 + 3 + 1 + 10 + 3 + 1 + 2) step(1'b0, 1'b1, 1'b0, 1'b1);
    run_until(MG, 0, 1'b1, 1'b0, 1'b0);
    // Pedestrian pulse at counter 5 with no side car
    run_until(MG, 5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    run_until(PW, 0, 1'b1, 1'b0, 1'b0);
    run_until(MG, 0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    // Pedestrian held through the walk phase
    run_until(MG, 3, 1'b1, 1'b0, 1'b0);
    run_until(PW, 0, 1'b1, 1'b1, 1'b0);
    run_until(MG, 0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    // Tick held low in MAIN_YELLOW
    run_until(MY, 1, 1'b1, 1'b0, 1'b1);
    repeat (100) step(1'b0, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    // Asynchronous reset in SIDE_GREEN at counter 4
    run_until(SG, 4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    check("async_rst_main", mainTraffic, 3'b001);
    check("async_rst_side", sideTraffic, 3'b100);
    check("async_rst_counter", counter, 0);
    check("async_rst_pending", ped_pending, 0);
    check("async_rst_walk", walk, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) s_rand = ~s_rand;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0, s_rand);
    end
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
